// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage: loads/stores on a req/gnt/rvalid bus, passthrough to writeback
module mem_access #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op_type,
  input  logic [4:0]      op_spec,
  input  logic [4:0]      rd_ind,
  input  logic [XLEN-1:0] rd_in,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] rs2_dat,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd_ind,
  output logic [XLEN-1:0] wb_rd_dat,
  output logic            wb_we,
  output logic            exc_misalign,
  output logic            exc_bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_store;
  logic [2:0]      r_spec;
  logic [4:0]      r_rd_ind;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_wb_dat;
  logic            r_wb_we;
  logic            r_exc_mis;
  logic            r_exc_bus;

  logic            w_acc;
  logic            w_is_mem;
  logic            w_legal;
  logic            w_mis;
  logic            w_tmo;
  logic            w_ld_done;
  logic            w_st_done;
  logic [XLEN-1:0] w_rshift;
  logic [XLEN-1:0] w_load;
  logic [3:0]      w_be;

  assign w_acc    = in_valid && in_ready;
  assign w_is_mem = (op_type == 4'b0001);

  always_comb begin
    w_legal = 1'b0;
    case (op_spec)
      5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10: w_legal = 1'b1;
      default:                                         w_legal = 1'b0;
    endcase
  end

  assign w_mis = ((op_spec[1:0] == 2'd1) && mem_addr[0]) ||
                 ((op_spec[1:0] == 2'd2) && (mem_addr[1:0] != 2'b00));

  // Timeout compare is gated so TIMEOUT_CYC = 0 never fires.
  assign w_tmo = (TIMEOUT_CYC != 0) && (r_cnt == TMO_LAST);

  assign w_ld_done = !r_store && dmem_rvalid &&
                     (((r_state == S_REQ) && dmem_gnt) || (r_state == S_WAIT));
  assign w_st_done = r_store && (r_state == S_REQ) && dmem_gnt;

  assign w_rshift = dmem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = w_rshift;
    case (r_spec[1:0])
      2'd0:    w_load = r_spec[2] ? {{(XLEN-8){1'b0}}, w_rshift[7:0]}
                                  : {{(XLEN-8){w_rshift[7]}}, w_rshift[7:0]};
      2'd1:    w_load = r_spec[2] ? {{(XLEN-16){1'b0}}, w_rshift[15:0]}
                                  : {{(XLEN-16){w_rshift[15]}}, w_rshift[15:0]};
      default: w_load = w_rshift;
    endcase
  end

  always_comb begin
    w_be = 4'b1111;
    case (r_spec[1:0])
      2'd0:    w_be = 4'b0001 << r_addr[1:0];
      2'd1:    w_be = 4'b0011 << r_addr[1:0];
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    dmem_req = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_acc) w_next = (w_is_mem && w_legal && !w_mis) ? S_REQ : S_HOLD;
      end
      S_REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt)   w_next = (r_store || dmem_rvalid) ? S_HOLD : S_WAIT;
        else if (w_tmo) w_next = S_HOLD;
      end
      S_WAIT: begin
        if (dmem_rvalid || w_tmo) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (wb_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_cnt     <= '0;
      r_store   <= 1'b0;
      r_spec    <= '0;
      r_rd_ind  <= '0;
      r_addr    <= '0;
      r_rs2     <= '0;
      r_wb_dat  <= '0;
      r_wb_we   <= 1'b0;
      r_exc_mis <= 1'b0;
      r_exc_bus <= 1'b0;
    end else begin
      if ((w_next == S_REQ || w_next == S_WAIT) && (w_next != r_state)) r_cnt <= '0;
      else if (r_state == S_REQ || r_state == S_WAIT)                    r_cnt <= r_cnt + 1'b1;

      if (w_acc) begin
        r_store   <= op_spec[3];
        r_spec    <= op_spec[2:0];
        r_rd_ind  <= rd_ind;
        r_addr    <= mem_addr;
        r_rs2     <= rs2_dat;
        r_exc_bus <= 1'b0;
        r_exc_mis <= w_is_mem && w_legal && w_mis;
        // Unlisted memory specs fall through as passthrough but never write the register file.
        r_wb_dat  <= (w_is_mem && w_legal) ? '0 : rd_in;
        r_wb_we   <= !w_is_mem && (rd_ind != 5'd0);
      end else if (w_ld_done) begin
        r_wb_dat <= w_load;
        r_wb_we  <= (r_rd_ind != 5'd0);
      end else if ((r_state == S_REQ || r_state == S_WAIT) && (w_next == S_HOLD) && !w_st_done) begin
        r_exc_bus <= 1'b1;
        r_wb_we   <= 1'b0;
      end
    end
  end

  always_comb begin
    dmem_we      = dmem_req && r_store;
    dmem_addr    = dmem_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
    dmem_be      = dmem_req ? w_be : 4'b0000;
    dmem_wdata   = dmem_req ? (r_rs2 << {r_addr[1:0], 3'b000}) : '0;
    wb_valid     = (r_state == S_HOLD);
    wb_rd_ind    = wb_valid ? r_rd_ind : 5'd0;
    wb_rd_dat    = wb_valid ? r_wb_dat : '0;
    wb_we        = wb_valid && r_wb_we;
    exc_misalign = wb_valid && r_exc_mis;
    exc_bus      = wb_valid && r_exc_bus;
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  op_type;
  logic [4:0]  op_spec, rd_ind;
  logic [31:0] rd_in, mem_addr, rs2_dat;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_ready, wb_we, exc_misalign, exc_bus;
  logic [4:0]  wb_rd_ind;
  logic [31:0] wb_rd_dat;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  always #5 clk = ~clk;

  mem_access #(.XLEN(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_type(op_type), .op_spec(op_spec), .rd_ind(rd_ind),
    .rd_in(rd_in), .mem_addr(mem_addr), .rs2_dat(rs2_dat),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_ind(wb_rd_ind),
    .wb_rd_dat(wb_rd_dat), .wb_we(wb_we),
    .exc_misalign(exc_misalign), .exc_bus(exc_bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] t, input logic [4:0] s, input logic [4:0] rd,
                       input logic [31:0] rdin, input logic [31:0] addr, input logic [31:0] rs2);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 20);
    check("issue_in_ready", in_ready, 1);
    in_valid = 1'b1; op_type = t; op_spec = s; rd_ind = rd;
    rd_in = rdin; mem_addr = addr; rs2_dat = rs2;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_wb(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!wb_valid && c < 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; op_type = '0; op_spec = '0; rd_ind = '0;
    rd_in = '0; mem_addr = '0; rs2_dat = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_exc", {exc_misalign, exc_bus}, 0);

    // Passthrough, rd 5 then rd 0, then unlisted memory spec
    issue(4'd0, 5'd0, 5'd5, 32'h1234, 32'h0, 32'h0);
    wait_wb(cyc);
    check("pt_latency", cyc, 1);
    check("pt_dat", wb_rd_dat, 32'h1234);
    check("pt_we", wb_we, 1);
    check("pt_rd", wb_rd_ind, 5);
    issue(4'd0, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0);
    wait_wb(cyc);
    check("pt_rd0_we", wb_we, 0);
    issue(4'd1, 5'd3, 5'd6, 32'h5555, 32'h10, 32'h0);
    wait_wb(cyc);
    check("unl_latency", cyc, 1);
    check("unl_dat", wb_rd_dat, 32'h5555);
    check("unl_we", wb_we, 0);
    check("unl_req", dmem_req, 0);

    // LB at 0x1003, gnt and rvalid one cycle apart
    issue(4'd1, 5'd0, 5'd3, 32'h0, 32'h1003, 32'h0);
    @(negedge clk);
    check("lb_req", dmem_req, 1);
    check("lb_addr", dmem_addr, 32'h1000);
    check("lb_be", dmem_be, 4'b1000);
    check("lb_we", dmem_we, 0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check("lb_wait_req", dmem_req, 0);
    check("lb_wait_valid", wb_valid, 0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FF00;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("lb_valid", wb_valid, 1);
    check("lb_dat", wb_rd_dat, 32'hFFFF_FF80);
    check("lb_wb_we", wb_we, 1);

    // LBU, gnt and rvalid in the same cycle
    issue(4'd1, 5'd4, 5'd3, 32'h0, 32'h1003, 32'h0);
    @(negedge clk);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FF00;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    check("lbu_valid", wb_valid, 1);
    check("lbu_dat", wb_rd_dat, 32'h0000_0080);

    // SH at 0x2002, gnt on the last cycle before timeout
    issue(4'd1, 5'd9, 5'd4, 32'h0, 32'h2002, 32'hAAAA_BEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sh_req", dmem_req, 1);
      check("sh_addr", dmem_addr, 32'h2000);
      check("sh_be", dmem_be, 4'b1100);
      check("sh_wdata_hi", dmem_wdata[31:16], 16'hBEEF);
      check("sh_dmem_we", dmem_we, 1);
      if (i == 3) dmem_gnt = 1'b1;
    end
    @(negedge clk);
    dmem_gnt = 1'b0;
    check("sh_valid", wb_valid, 1);
    check("sh_wb_we", wb_we, 0);
    check("sh_exc", {exc_misalign, exc_bus}, 0);
    check("sh_req_done", dmem_req, 0);

    // Misaligned LW
    issue(4'd1, 5'd2, 5'd8, 32'h0, 32'h3001, 32'h0);
    @(negedge clk);
    check("mis_req", dmem_req, 0);
    check("mis_valid", wb_valid, 1);
    check("mis_exc", exc_misalign, 1);
    check("mis_we", wb_we, 0);
    check("mis_bus", exc_bus, 0);
    @(negedge clk);
    check("mis_pulse_end", exc_misalign, 0);

    // Timeout: gnt never comes
    issue(4'd1, 5'd2, 5'd9, 32'h0, 32'h4000, 32'h0);
    cyc = 0;
    @(negedge clk);
    while (dmem_req && cyc < 10) begin
      cyc++;
      @(negedge clk);
    end
    check("tmo_req_cycles", cyc, 4);
    check("tmo_valid", wb_valid, 1);
    check("tmo_exc_bus", exc_bus, 1);
    check("tmo_we", wb_we, 0);

    // Reset asserted in REQ drops dmem_req before the next edge
    issue(4'd1, 5'd2, 5'd9, 32'h0, 32'h5000, 32'h0);
    @(negedge clk);
    check("rreq_req_before", dmem_req, 1);
    #1 rst_n = 1'b1;
    #1 check("rreq_req_async", dmem_req, 0);
    @(negedge clk);
    rst_n = 1'b0;

    // Reset asserted in WAIT; a late rvalid is ignored
    issue(4'd1, 5'd2, 5'd9, 32'h0, 32'h5000, 32'h0);
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check("rwait_in_ready", in_ready, 0);
    #1 rst_n = 1'b1;
    #1;
    check("rwait_in_ready_async", in_ready, 1);
    check("rwait_req", dmem_req, 0);
    check("rwait_valid", wb_valid, 0);
    @(negedge clk);
    rst_n = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("late_rvalid_valid", wb_valid, 0);
    check("late_rvalid_ready", in_ready, 1);

    // Backpressure after LH; a pending op must wait for IDLE
    wb_ready = 1'b0;
    issue(4'd1, 5'd1, 5'd11, 32'h0, 32'h6002, 32'h0);
    @(negedge clk);
    check("lh_be", dmem_be, 4'b1100);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hF00D_0000;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    in_valid = 1'b1; op_type = 4'd0; op_spec = 5'd0; rd_ind = 5'd7; rd_in = 32'hCAFE;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", wb_valid, 1);
      check("bp_dat", wb_rd_dat, 32'hFFFF_F00D);
      check("bp_rd", wb_rd_ind, 11);
      check("bp_we", wb_we, 1);
      check("bp_in_ready", in_ready, 0);
      if (i < 4) @(negedge clk);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", wb_valid, 0);
    check("bp_release_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_valid", wb_valid, 1);
    check("bp_next_dat", wb_rd_dat, 32'hCAFE);
    check("bp_next_rd", wb_rd_ind, 7);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline stage s4 (memory access). It sits directly downstream of the execute stage and consumes its registered rd_out, mem_addr_out and op fields.
- Performs loads and stores on a request/grant/rvalid data-memory bus. Handles byte-lane alignment, sign/zero extension, misalignment and bus timeout.
- Passes non-memory results through to writeback under a valid/ready handshake.

Parameters:
- XLEN, 32, datapath and address width.
- TIMEOUT_CYC, 255, max cycles waiting for dmem_gnt or dmem_rvalid before bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high (asserted = 1).
- in_valid  in  1  execute stage has an op.
- in_ready  out  1  stage can accept (IDLE and output not held).
- op_type  in  4  4'b0001 = load/store; any other value = passthrough.
- op_spec  in  5  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU, 8 SB, 9 SH, 10 SW.
- rd_ind  in  5  destination register.
- rd_in  in  XLEN  execute result (passthrough ops).
- mem_addr  in  XLEN  effective address.
- rs2_dat  in  XLEN  store data.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  XLEN  word-aligned address, low 2 bits = 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  lane-shifted store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  load word.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback consumes.
- wb_rd_ind  out  5  destination.
- wb_rd_dat  out  XLEN  result.
- wb_we  out  1  register write enable (0 for stores, 0 for rd_ind = 0).
- exc_misalign  out  1  pulse with wb_valid for a misaligned access.
- exc_bus  out  1  pulse with wb_valid for a timeout.

Behaviour:
- Reset: state = IDLE, every output 0 except in_ready = 1; timeout counter = 0.
- Reset mid-transaction drops dmem_req immediately. A late dmem_gnt or dmem_rvalid arriving in IDLE is ignored.
- Accept an op when in_valid & in_ready; latch every input field.
- States: IDLE, REQ, WAIT, HOLD.
- Passthrough op: IDLE -> HOLD.
  - wb_valid is asserted the cycle after accept.
  - wb_rd_dat = rd_in.
  - wb_we = (rd_ind != 0).
- Misaligned access (halfword with addr[0] = 1, or word with addr[1:0] != 0): IDLE -> HOLD with no bus request; exc_misalign = 1, wb_we = 0.
- Unlisted op_spec under op_type 4'b0001: treated as passthrough with wb_we = 0.
- Aligned memory op: IDLE -> REQ; dmem_req = 1 from the cycle after accept.
  - dmem_req, addr, we, be and wdata stay stable until dmem_gnt.
  - Store: gnt -> HOLD.
  - Load: gnt -> WAIT; dmem_rvalid -> HOLD and capture the extracted data.
  - dmem_rvalid in the same cycle as gnt counts as the load completing (REQ -> HOLD directly).
- Byte enables:
  - Byte: 1 << addr[1:0].
  - Half: 4'b0011 << addr[1:0].
  - Word: 4'b1111.
- Store data: wdata = rs2_dat shifted left by 8*addr[1:0]; unused lanes are don't-care.
- Load data: shift rdata right by 8*addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- HOLD:
  - wb_* outputs held stable while wb_valid & !wb_ready.
  - On wb_ready -> IDLE; in_ready returns next cycle, so there is no back-to-back accept on the same edge.
  - Exception pulses last exactly the cycles wb_valid is high for that op.
- Timeout:
  - Counter clears on entry to REQ or WAIT and increments each cycle in those states.
  - At TIMEOUT_CYC: drop dmem_req, go to HOLD with exc_bus = 1 and wb_we = 0.
- Minimum latency:
  - Passthrough: 1 cycle accept -> wb_valid.
  - Store with immediate gnt: 2 cycles.
  - Load with gnt and rvalid one cycle apart: 3 cycles.

Test Plan:
- Passthrough: op_type 0, rd_ind 5, rd_in 0x1234 -> wb_valid next cycle, wb_rd_dat 0x1234, wb_we 1. Same op with rd_ind 0 -> wb_we 0.
- LB at 0x1003, rdata 0x80FF_FF00 -> dmem_addr 0x1000, be 4'b1000, wb_rd_dat 0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- SH at 0x2002, rs2_dat 0xAAAA_BEEF; gnt held low 3 cycles -> dmem_req/addr/be/wdata stable throughout; be 4'b1100, wdata[31:16] = 0xBEEF, wb_we 0.
- LW at 0x3001 -> no dmem_req, wb_valid with exc_misalign 1, wb_we 0.
- TIMEOUT_CYC = 4, LW with gnt never asserted -> dmem_req drops after 4 cycles in REQ, exc_bus 1. Then assert rst_n during WAIT of a new load -> outputs 0 asynchronously, and a later rvalid is ignored.
- Backpressure: wb_ready low 5 cycles after an LH -> wb_* stable and in_ready 0; accept resumes the cycle after wb_ready.
